// File: rtl/dm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_pkg : shared types and constants for the data-memory responder   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dm_pkg;

  localparam int c_DEF_ADDR_W  = 12;
  localparam int c_DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Naturally aligned byte, halfword and word lane patterns only.
  localparam logic [3:0] c_BE_B0 = 4'b0001;
  localparam logic [3:0] c_BE_B1 = 4'b0010;
  localparam logic [3:0] c_BE_B2 = 4'b0100;
  localparam logic [3:0] c_BE_B3 = 4'b1000;
  localparam logic [3:0] c_BE_H0 = 4'b0011;
  localparam logic [3:0] c_BE_H1 = 4'b1100;
  localparam logic [3:0] c_BE_W  = 4'b1111;

  function automatic logic is_legal_be(input logic [3:0] be);
    logic ok;
    case (be)
      c_BE_B0, c_BE_B1, c_BE_B2, c_BE_B3, c_BE_H0, c_BE_H1, c_BE_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_array : word-wide synchronous RAM, lane write mask, reg'd read   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dm_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-3:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_be,
  output logic [31:0]       o_rdata
);

  localparam int c_DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] r_mem [c_DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < 4; l++) begin
        if (i_be[l]) r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_responder : fixed-latency MEM-stage load/store target with stall |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = c_DEF_ADDR_W,
  parameter int LATENCY = c_DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);
  localparam int         c_IDX_W    = ADDR_W - 2;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic               r_err;
  logic [c_IDX_W-1:0] r_idx;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [3:0]         r_lane_mask;
  logic               r_resp_err;
  logic               w_accept;
  logic               w_access;
  logic               w_req_legal;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [31:0]        w_ram_q;
  logic [31:0]        w_lane_bits;
  logic               w_unused;

  assign w_unused    = ^req_addr[1:0];
  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_req_legal = (req_addr[31:ADDR_W] == '0) && is_legal_be(req_be);
  assign w_ram_we    = w_access && r_we && !r_err;
  assign w_ram_re    = w_access && !r_we && !r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) w_next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_lane_mask <= 4'd0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_CNT_INIT;
        r_we    <= req_we;
        r_err   <= !w_req_legal;
        r_idx   <= req_addr[ADDR_W-1:2];
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Lane mask and error are captured with the RAM read so the response holds until the next access.
      if (w_access) begin
        r_resp_err  <= r_err;
        r_lane_mask <= (r_we || r_err) ? 4'd0 : r_be;
      end
    end
  end

  always_comb begin
    w_lane_bits = 32'd0;
    for (int b = 0; b < 4; b++) begin
      w_lane_bits[8*b +: 8] = {8{r_lane_mask[b]}};
    end
  end

  assign resp_rdata = w_ram_q & w_lane_bits;
  assign resp_err   = r_resp_err;

  dm_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dm_responder : three responders (LATENCY 2, 1, 15) vs. model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_dm_responder;

  localparam int N_INST = 3;

  logic        clk = 1'b0;
  logic        rst        [N_INST];
  logic        req_valid  [N_INST];
  logic        req_we     [N_INST];
  logic [31:0] req_addr   [N_INST];
  logic [31:0] req_wdata  [N_INST];
  logic [3:0]  req_be     [N_INST];
  logic        req_ready  [N_INST];
  logic        resp_valid [N_INST];
  logic [31:0] resp_rdata [N_INST];
  logic        resp_err   [N_INST];
  logic        stall      [N_INST];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%h exp=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;

    dm_responder #(
      .ADDR_W  (12),
      .LATENCY (L)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .req_ready  (req_ready[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .stall      (stall[g])
    );

    // Transaction-level model: cycle of accept, pending request, memory image, held response.
    int          cyc = 0;
    int          acc = -1;
    logic        p_we;
    logic        p_err;
    logic [3:0]  p_idx;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    logic [31:0] mem [16];
    logic [31:0] e_rdata  = 32'd0;
    logic        e_err    = 1'b0;
    bit          e_rd_chk = 1'b1;

    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        acc      = -1;
        e_rdata  = 32'd0;
        e_err    = 1'b0;
        e_rd_chk = 1'b1;
      end else begin
        if (acc < 0) begin
          if (req_valid[g]) begin
            acc     = cyc;
            p_we    = req_we[g];
            p_idx   = req_addr[g][5:2];
            p_wdata = req_wdata[g];
            p_be    = req_be[g];
            p_err   = (req_addr[g][31:12] != 20'd0) ||
                      !(req_be[g] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
          end
        end else if (cyc - acc == L) begin
          e_err = p_err;
          if (p_err) begin
            e_rdata  = 32'd0;
            e_rd_chk = 1'b1;
          end else if (p_we) begin
            mem[p_idx] = (mem[p_idx] & ~lanes(p_be)) | (p_wdata & lanes(p_be));
            e_rd_chk   = 1'b0;
          end else begin
            e_rdata  = mem[p_idx] & lanes(p_be);
            e_rd_chk = 1'b1;
          end
        end else if (cyc - acc == L + 1) begin
          acc = -1;
        end
        cyc++;
      end
    end

    always @(negedge clk) begin
      bit idle;
      int k;
      if (chk_en) begin
        idle = (acc < 0);
        k    = idle ? 0 : cyc - acc;
        check("req_ready", g, 32'(req_ready[g]), 32'(idle));
        check("resp_valid", g, 32'(resp_valid[g]), 32'(!idle && k == L + 1));
        check("stall", g, 32'(stall[g]), 32'((idle && req_valid[g]) || (!idle && k >= 1 && k <= L)));
        check("resp_err", g, 32'(resp_err[g]), 32'(e_err));
        if (e_rd_chk) check("resp_rdata", g, resp_rdata[g], e_rdata);
      end
    end
  end

  // Called away from the clock edge; returns #1 into the RESP cycle with req_valid dropped.
  task automatic access(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int lat);
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    req_valid[i] = 1'b1;
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid[i]) begin
        req_valid[i] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL resp_timeout inst%0d got=none exp=resp_valid within 40 cycles", i);
    req_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preinit(input int i, output logic [31:0] w30);
    int lat;
    logic [31:0] d;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      if (w == 12) w30 = d;
      access(i, 1'b1, 32'(w * 4), d, 4'hF, lat);
    end
    step();
  endtask

  task automatic rand_access(input int i);
    logic [3:0]  legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [31:0] a;
    logic [3:0]  be;
    int          lat;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
    if ($urandom_range(0, 3) == 0) be = 4'($urandom_range(0, 15));
    else                           be = legal_be[$urandom_range(0, 6)];
    access(i, 1'($urandom_range(0, 1)), a, $urandom, be, lat);
    repeat ($urandom_range(0, 2)) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          nresp;
    int          nstall0;
    int          nst;
    logic [31:0] w30;

    for (int i = 0; i < N_INST; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'd0;
    end
    step();
    chk_en = 1'b1;
    check("rst_ready", 0, 32'(req_ready[0]), 32'd1);
    check("rst_rdata", 0, resp_rdata[0], 32'd0);
    step();
    for (int i = 0; i < N_INST; i++) rst[i] = 1'b0;
    step();

    // ---------------- LATENCY = 2 ----------------
    preinit(0, w30);
    access(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'b1111, lat);
    check("st_latency", 0, 32'(lat), 32'd3);
    step();
    access(0, 1'b0, 32'h010, 32'h0, 4'b1111, lat);
    check("ld_latency", 0, 32'(lat), 32'd3);
    check("ld_deadbeef", 0, resp_rdata[0], 32'hDEADBEEF);
    check("ld_err0", 0, 32'(resp_err[0]), 32'd0);
    step();
    access(0, 1'b1, 32'h020, 32'h11223344, 4'b1111, lat);
    step();
    access(0, 1'b1, 32'h022, 32'hAABBCCDD, 4'b0100, lat);
    step();
    access(0, 1'b0, 32'h020, 32'h0, 4'b1111, lat);
    check("merge_word", 0, resp_rdata[0], 32'h11BB3344);
    step();
    access(0, 1'b0, 32'h020, 32'h0, 4'b1100, lat);
    check("merge_hi", 0, resp_rdata[0], 32'h11BB0000);
    step();
    access(0, 1'b0, 32'h00001000, 32'h0, 4'b1111, lat);
    check("oor_err", 0, 32'(resp_err[0]), 32'd1);
    check("oor_rdata", 0, resp_rdata[0], 32'd0);
    step();
    access(0, 1'b0, 32'h020, 32'h0, 4'b0101, lat);
    check("badbe_err", 0, 32'(resp_err[0]), 32'd1);
    check("badbe_rdata", 0, resp_rdata[0], 32'd0);
    step();
    access(0, 1'b1, 32'h020, 32'h0, 4'b0101, lat);
    step();
    access(0, 1'b1, 32'h00001020, 32'h0, 4'b1111, lat);
    step();
    access(0, 1'b0, 32'h020, 32'h0, 4'b1111, lat);
    check("unchanged", 0, resp_rdata[0], 32'h11BB3344);
    step();

    // Reset in the second WAIT cycle of a store discards it.
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h030;
    req_wdata[0] = ~w30;
    req_be[0]    = 4'b1111;
    req_valid[0] = 1'b1;
    step();
    step();
    rst[0]       = 1'b1;
    req_valid[0] = 1'b0;
    step();
    check("rstw_valid", 0, 32'(resp_valid[0]), 32'd0);
    check("rstw_ready", 0, 32'(req_ready[0]), 32'd1);
    check("rstw_stall", 0, 32'(stall[0]), 32'd0);
    check("rstw_rdata", 0, resp_rdata[0], 32'd0);
    rst[0] = 1'b0;
    step();
    access(0, 1'b0, 32'h030, 32'h0, 4'b1111, lat);
    check("rstw_prior", 0, resp_rdata[0], w30);
    step();
    repeat (150) rand_access(0);

    // ---------------- LATENCY = 1 ----------------
    preinit(1, w30);
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h010;
    req_be[1]    = 4'b1111;
    req_valid[1] = 1'b1;
    nresp   = 0;
    nstall0 = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (resp_valid[1]) nresp++;
      if (!stall[1]) nstall0++;
    end
    req_valid[1] = 1'b0;
    check("b2b_resp", 1, 32'(nresp), 32'd10);
    check("b2b_stall0", 1, 32'(nstall0), 32'd10);
    step();
    repeat (100) rand_access(1);

    // ---------------- LATENCY = 15 ----------------
    preinit(2, w30);
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h010;
    req_be[2]    = 4'b1111;
    req_valid[2] = 1'b1;
    nst = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (stall[2]) nst++;
      else break;
    end
    check("l15_stall", 2, 32'(nst), 32'd16);
    check("l15_resp", 2, 32'(resp_valid[2]), 32'd1);
    req_valid[2] = 1'b0;
    step();
    repeat (30) rand_access(2);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
